// File: rtl/axi_slice_rr_arbiter.sv
// Round-robin arbiter with burst locking in front of a registered (non-fall-through) FIFO.
// Beats of one burst are never interleaved with another requester's beats.
module axi_slice_rr_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 2,
  parameter int IDX_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 testmode_i,
  input  logic [NUM_IN-1:0]                    valid_i,
  output logic [NUM_IN-1:0]                    ready_o,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    data_i,
  input  logic [NUM_IN-1:0]                    last_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic                                 last_o,
  output logic [IDX_W-1:0]                     idx_o,
  output logic                                 busy_o
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_IN - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic             full;
  logic             push;
  logic             pop;
  logic             sel_last;
  entry_t           wr_entry;
  entry_t           rd_entry;
  entry_t           mem [BUFFER_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             unused_testmode;

  // The FIFO has no scan-specific behaviour; the pin is kept for interface compatibility.
  assign unused_testmode = testmode_i;

  // Scan downwards so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant     = lock_idx;
    grant_vld = 1'b0;
    cand      = '0;
    if (state == LOCKED) begin
      grant_vld = 1'b1;
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_IN);
        if (valid_i[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (grant_vld && !full) ready_o[grant] = valid_i[grant];
  end

  assign push     = |ready_o;
  assign sel_last = last_i[grant];
  assign wr_entry = '{idx: grant, last: sel_last, data: data_i[grant]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      busy_o   <= 1'b0;
    end else if (push) begin
      if (sel_last) begin
        state  <= IDLE;
        busy_o <= 1'b0;
        rr_ptr <= idx_inc(grant);
      end else begin
        state    <= LOCKED;
        busy_o   <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

  // ---- output FIFO: push = accepted input beat, pop = downstream handshake ----
  assign valid_o = (count != '0);
  assign full    = (count == CNT_W'(BUFFER_DEPTH));
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];
  assign data_o   = rd_entry.data;
  assign last_o   = rd_entry.last;
  assign idx_o    = rd_entry.idx;

endmodule

// File: tb/tb_axi_slice_rr_arbiter.sv
// Scoreboard bench for axi_slice_rr_arbiter: a queue-based reference model predicts
// handshakes and output beats; a separate monitor pops and compares each output beat.
module tb_axi_slice_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BD = 2;
  localparam int IW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   testmode;
  logic [N-1:0]           valid_i;
  logic [N-1:0]           ready_o;
  logic [N-1:0][DW-1:0]   data_i;
  logic [N-1:0]           last_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [DW-1:0]          data_o;
  logic                   last_o;
  logic [IW-1:0]          idx_o;
  logic                   busy_o;

  axi_slice_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .BUFFER_DEPTH(BD)) dut (
    .clk_i(clk), .rst_i(rst), .testmode_i(testmode),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
    .idx_o(idx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester drivers ----------------
  bit          vld [N];
  bit          hold[N];
  bit          auto_on[N];
  int          rem [N];
  int          seq [N];
  logic [31:0] salt[N];
  bit          rand_mode = 0;
  logic [N-1:0] acc;
  int          accepted_cnt = 0;

  task automatic apply_drive();
    for (int i = 0; i < N; i++) begin
      valid_i[i] = vld[i] && !hold[i];
      data_i[i]  = {16'(i), 16'(seq[i]), salt[i]};
      last_i[i]  = (rem[i] == 1);
    end
  endtask

  task automatic start_burst(input int i, input int len);
    vld[i]  = 1;
    rem[i]  = len;
    salt[i] = $urandom;
  endtask

  task automatic clear_drivers();
    for (int i = 0; i < N; i++) begin
      vld[i] = 0; hold[i] = 0; auto_on[i] = 0; rem[i] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc = ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        accepted_cnt++;
        seq[i]++;
        rem[i]--;
        salt[i] = $urandom;
        if (rem[i] == 0) begin
          if (auto_on[i]) start_burst(i, 1);
          else vld[i] = 0;
        end
      end
      if (rand_mode) begin
        if (!vld[i]) begin
          hold[i] = 0;
          if ($urandom_range(0, 3) == 0) start_burst(i, $urandom_range(1, 4));
        end else if (acc[i]) begin
          hold[i] = ($urandom_range(0, 3) == 0);
        end else if (hold[i] && $urandom_range(0, 1) == 0) begin
          hold[i] = 0;
        end
      end
    end
    if (rand_mode) ready_i = ($urandom_range(0, 9) < 7);
    apply_drive();
  endtask

  task automatic drain();
    int  guard = 0;
    bit  busy_left = 1;
    for (int i = 0; i < N; i++) begin hold[i] = 0; auto_on[i] = 0; end
    ready_i = 1;
    apply_drive();
    while (busy_left && guard < 300) begin
      step();
      guard++;
      busy_left = valid_o;
      for (int i = 0; i < N; i++) if (vld[i]) busy_left = 1;
    end
    if (busy_left) chk("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1;
    clear_drivers();
    apply_drive();
    #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_busy_o", busy_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          idx;
    bit          last;
    logic [63:0] data;
  } beat_t;

  beat_t        expq[$];
  int           owner = -1;
  int           mptr  = 0;
  int           occ   = 0;
  int           waitcnt[N];
  int           m_cand, m_best, m_dist;
  logic [N-1:0] m_rdy;
  bit           m_full, m_pop;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      owner = -1; mptr = 0; occ = 0;
      expq.delete();
      for (int i = 0; i < N; i++) waitcnt[i] = 0;
    end else begin
      m_full = (occ >= BD);
      m_pop  = (occ > 0) && ready_i;
      m_cand = -1;
      if (owner >= 0) begin
        if (valid_i[owner]) m_cand = owner;
      end else begin
        m_best = N;
        for (int i = 0; i < N; i++) begin
          m_dist = (i - mptr + N) % N;
          if (valid_i[i] && m_dist < m_best) begin
            m_best = m_dist;
            m_cand = i;
          end
        end
      end
      m_rdy = '0;
      if (m_cand >= 0 && !m_full) m_rdy[m_cand] = 1'b1;
      chk("ready_o", ready_o, m_rdy);
      chk("busy_o", busy_o, owner >= 0);
      chk("valid_o", valid_o, occ > 0);
      for (int i = 0; i < N; i++) if (!valid_i[i]) waitcnt[i] = 0;
      if (m_rdy != '0) begin
        expq.push_back('{idx: m_cand, last: last_i[m_cand], data: data_i[m_cand]});
        if (owner < 0) begin
          chk("starvation", waitcnt[m_cand] <= N, 1);
          waitcnt[m_cand] = 0;
        end
        if (last_i[m_cand]) begin
          for (int j = 0; j < N; j++) if (j != m_cand && valid_i[j]) waitcnt[j]++;
          owner = -1;
          mptr  = (m_cand + 1) % N;
        end else begin
          owner = m_cand;
        end
      end
      occ = occ + ((m_rdy != '0) ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // ---------------- output monitor ----------------
  int    out_idx[$];
  bit    out_last[$];
  bit    prev_last = 1;
  int    prev_idx  = 0;
  beat_t got;

  always begin
    @(negedge clk);
    if (rst) begin
      prev_last = 1;
    end else if (valid_o && ready_i) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        got = expq.pop_front();
        chk("idx_o", idx_o, got.idx);
        chk("last_o", last_o, got.last);
        chk("data_o", data_o, got.data);
      end
      if (!prev_last) chk("no_interleave", idx_o, prev_idx);
      prev_last = last_o;
      prev_idx  = idx_o;
      out_idx.push_back(int'(idx_o));
      out_last.push_back(last_o);
    end
  end

  // ---------------- directed and random sequences ----------------
  int exp_lock[7] = '{2, 2, 2, 2, 3, 0, 1};
  int exp_gap[5]  = '{1, 1, 1, 2, 0};

  initial begin
    rst = 1; testmode = 0; ready_i = 0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; salt[i] = '0; end
    clear_drivers();
    apply_drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_valid_o", valid_o, 0);
    chk("init_busy_o", busy_o, 0);
    chk("init_ready_o", ready_o, 0);
    rst = 0;

    // round robin over single-beat bursts
    ready_i = 1;
    out_idx.delete(); out_last.delete();
    for (int i = 0; i < N; i++) begin auto_on[i] = 1; start_burst(i, 1); end
    apply_drive();
    for (int c = 0; c < 12; c++) step();
    drain();
    chk("rr_count_ok", out_idx.size() >= 8, 1);
    for (int k = 0; k < 8 && k < out_idx.size(); k++) chk("rr_order", out_idx[k], k % N);

    // burst lock: req 2 holds the channel for four beats
    do_reset();
    ready_i = 1;
    start_burst(0, 1); start_burst(1, 1);
    apply_drive();
    drain();
    out_idx.delete(); out_last.delete();
    start_burst(2, 4); start_burst(0, 1); start_burst(1, 1); start_burst(3, 1);
    apply_drive();
    drain();
    chk("lock_count", out_idx.size(), 7);
    for (int k = 0; k < 7 && k < out_idx.size(); k++) begin
      chk("lock_order", out_idx[k], exp_lock[k]);
      chk("lock_last", out_last[k], (k >= 3));
    end

    // backpressure: only BUFFER_DEPTH beats taken while ready_i=0
    ready_i = 0;
    out_idx.delete(); out_last.delete();
    accepted_cnt = 0;
    start_burst(1, 6);
    apply_drive();
    for (int c = 0; c < 6; c++) step();
    chk("bp_accepts", accepted_cnt, BD);
    chk("bp_ready_o", ready_o, 0);
    drain();
    chk("bp_count", out_idx.size(), 6);
    for (int k = 0; k < out_idx.size(); k++) begin
      chk("bp_idx", out_idx[k], 1);
      chk("bp_last", out_last[k], (k == 5));
    end

    // lock with a gap: locked req 1 drops valid for three cycles
    do_reset();
    ready_i = 1;
    start_burst(0, 1);
    apply_drive();
    drain();
    out_idx.delete(); out_last.delete();
    start_burst(1, 3);
    apply_drive();
    step();
    hold[1] = 1;
    start_burst(0, 1); start_burst(2, 1);
    apply_drive();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gap_busy", busy_o, 1);
      chk("gap_ready", ready_o, 0);
    end
    hold[1] = 0;
    apply_drive();
    drain();
    chk("gap_count", out_idx.size(), 5);
    for (int k = 0; k < 5 && k < out_idx.size(); k++) chk("gap_order", out_idx[k], exp_gap[k]);

    // reset mid-burst with the FIFO full
    ready_i = 0;
    start_burst(3, 5);
    apply_drive();
    for (int c = 0; c < 4; c++) step();
    chk("pre_reset_busy", busy_o, 1);
    chk("pre_reset_valid", valid_o, 1);
    do_reset();
    ready_i = 1;
    out_idx.delete(); out_last.delete();
    for (int i = 0; i < N; i++) start_burst(i, 1);
    apply_drive();
    drain();
    chk("post_reset_first", (out_idx.size() > 0) ? out_idx[0] : -1, 0);

    // randomized traffic
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) step();
    rand_mode = 0;
    drain();
    chk("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
